// File: rtl/nem_mux_pkg.sv
// nem_mux_pkg: shared state type, relay timing defaults and select helpers for the nem_ohmux family.
package nem_mux_pkg;
    typedef enum logic [1:0] {OFF, BREAK, MAKE, STABLE} sel_state_e;
    localparam int DEF_BREAK_CYCLES = 4;
    localparam int DEF_MAKE_CYCLES  = 8;
    function automatic int sel_width(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction
    function automatic logic [15:0] onehot(input int idx, input int n);
        return idx < n ? (16'd1 << idx) : 16'd0;
    endfunction
endpackage

// File: rtl/nem_ohmux_sel_ctrl_if.sv
// nem_ohmux_sel_ctrl_if: select request handshake and relay select/status bundle.
interface nem_ohmux_sel_ctrl_if
    import nem_mux_pkg::*;
#(
    parameter int NUM_INPUTS = 2
);
    localparam int SEL_W = sel_width(NUM_INPUTS);
    logic                  req_valid;
    logic [SEL_W-1:0]      req_sel;
    logic                  req_off;
    logic                  req_ready;
    logic [NUM_INPUTS-1:0] S;
    logic [SEL_W-1:0]      cur_sel;
    logic                  sel_stable;
    logic                  sel_err;
    modport master(output req_valid, req_sel, req_off,
                   input req_ready, S, cur_sel, sel_stable, sel_err);
    modport slave(input req_valid, req_sel, req_off,
                  output req_ready, S, cur_sel, sel_stable, sel_err);
endinterface

// File: rtl/nem_dwell_timer.sv
// nem_dwell_timer: loadable down-counter that parks at zero; done while the count is zero.
module nem_dwell_timer #(
    parameter int W = 3
) (
    input  logic         CP,
    input  logic         CDN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge CP or negedge CDN)
        if (!CDN) cnt <= '0;
        else      cnt <= load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
    assign done = cnt == '0;
endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// nem_ohmux_sel_ctrl: break-before-make sequencer driving the one-hot relay selects of an nem_ohmux.
module nem_ohmux_sel_ctrl
    import nem_mux_pkg::*;
#(
    parameter int NUM_INPUTS   = 2,
    parameter int BREAK_CYCLES = DEF_BREAK_CYCLES,
    parameter int MAKE_CYCLES  = DEF_MAKE_CYCLES
) (
    input logic                 CP,
    input logic                 CDN,
    nem_ohmux_sel_ctrl_if.slave bus
);
    localparam int MAX_CYC = BREAK_CYCLES > MAKE_CYCLES ? BREAK_CYCLES : MAKE_CYCLES;
    localparam int CW      = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
    sel_state_e state;
    logic to_off, done, accept, in_range, go_make, go_break, reload, load;
    logic [CW-1:0] load_val;
    assign bus.req_ready = state == OFF || state == STABLE;
    always_comb begin
        accept   = bus.req_valid && bus.req_ready;
        in_range = 32'(bus.req_sel) < NUM_INPUTS;
        go_make  = accept && state == OFF && !bus.req_off && in_range;
        go_break = accept && state == STABLE &&
                   (bus.req_off || (in_range && bus.req_sel != bus.cur_sel));
        reload   = state == BREAK && done && !to_off;
        load     = go_make || go_break || reload;
        load_val = go_break ? CW'(BREAK_CYCLES - 1) : CW'(MAKE_CYCLES - 1);
    end
    nem_dwell_timer #(.W(CW)) u_timer (
        .CP(CP), .CDN(CDN), .load(load), .load_val(load_val), .done(done)
    );
    // cur_sel takes the new target at accept so BREAK->MAKE closes the right relay
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state          <= OFF;
            to_off         <= 1'b0;
            bus.S          <= '0;
            bus.cur_sel    <= '0;
            bus.sel_stable <= 1'b0;
            bus.sel_err    <= 1'b0;
        end else begin
            bus.sel_err <= accept && !bus.req_off && !in_range;
            case (state)
                OFF: if (go_make) begin
                    state       <= MAKE;
                    bus.S       <= NUM_INPUTS'(onehot(int'(bus.req_sel), NUM_INPUTS));
                    bus.cur_sel <= bus.req_sel;
                end
                BREAK: if (done) begin
                    state <= to_off ? OFF : MAKE;
                    bus.S <= to_off ? '0 : NUM_INPUTS'(onehot(int'(bus.cur_sel), NUM_INPUTS));
                end
                MAKE: if (done) begin
                    state          <= STABLE;
                    bus.sel_stable <= 1'b1;
                end
                STABLE: if (go_break) begin
                    state          <= BREAK;
                    to_off         <= bus.req_off;
                    bus.S          <= '0;
                    bus.sel_stable <= 1'b0;
                    bus.cur_sel    <= bus.req_off ? bus.cur_sel : bus.req_sel;
                end
                default: state <= OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// tb_nem_ohmux_sel_ctrl: randomized requests checked every cycle against a timeline model of relay events.
module tb_nem_ohmux_sel_ctrl;
    localparam int NI = 3, BC = 3, MC = 4, INF = 2147483647;
    logic CP = 1'b0, CDN = 1'b0;
    int checks = 0, failures = 0;
    int cyc = 0, s_on_at = INF, stable_at = INF, busy_end = 0, m_cur = 0, err_at = -1;
    logic m_rdy, m_stab, exp_err;
    logic [2:0] exp_s, prev_s = 3'b000;
    int a, b, x, o, n, r;

    nem_ohmux_sel_ctrl_if #(.NUM_INPUTS(NI)) bif ();
    nem_ohmux_sel_ctrl #(.NUM_INPUTS(NI), .BREAK_CYCLES(BC), .MAKE_CYCLES(MC)) dut (
        .CP(CP), .CDN(CDN), .bus(bif)
    );

    always #5 CP = ~CP;

    // model: each accept schedules absolute cycles for relay close, settle and ready
    assign m_rdy   = cyc >= busy_end;
    assign m_stab  = cyc >= stable_at;
    assign exp_s   = cyc >= s_on_at ? 3'(3'b001 << m_cur) : 3'b000;
    assign exp_err = cyc == err_at;

    always @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            s_on_at   <= INF;
            stable_at <= INF;
            busy_end  <= 0;
            m_cur     <= 0;
            err_at    <= -1;
        end else begin
            cyc <= cyc + 1;
            if (bif.req_valid && m_rdy) begin
                if (!bif.req_off && bif.req_sel >= NI) err_at <= cyc + 1;
                else if (!m_stab) begin
                    if (!bif.req_off) begin
                        m_cur     <= int'(bif.req_sel);
                        s_on_at   <= cyc + 1;
                        stable_at <= cyc + 1 + MC;
                        busy_end  <= cyc + 1 + MC;
                    end
                end else if (bif.req_off) begin
                    s_on_at   <= INF;
                    stable_at <= INF;
                    busy_end  <= cyc + 1 + BC;
                end else if (int'(bif.req_sel) != m_cur) begin
                    m_cur     <= int'(bif.req_sel);
                    s_on_at   <= cyc + 1 + BC;
                    stable_at <= cyc + 1 + BC + MC;
                    busy_end  <= cyc + 1 + BC + MC;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d t=%0t", nm, act, exp, cyc, $time);
        end
    endtask

    always @(negedge CP) begin
        chk("S", 32'(bif.S), 32'(exp_s));
        chk("sel_stable", 32'(bif.sel_stable), 32'(m_stab));
        chk("req_ready", 32'(bif.req_ready), 32'(m_rdy));
        chk("cur_sel", 32'(bif.cur_sel), 32'(m_cur));
        chk("sel_err", 32'(bif.sel_err), 32'(exp_err));
        chk("popcount_le1", 32'($countones(bif.S) <= 1), 1);
        chk("break_before_make", 32'(!(prev_s != 0 && bif.S != 0 && bif.S != prev_s)), 1);
        chk("stable_implies_sel", 32'(!bif.sel_stable || bif.S == 3'(3'b001 << bif.cur_sel)), 1);
        prev_s = bif.S;
    end

    task automatic idle(input int k);
        repeat (k) begin @(negedge CP); #1; end
    endtask

    task automatic send(input logic [1:0] sel, input logic off, output int acc);
        @(negedge CP); #1;
        bif.req_valid = 1'b1;
        bif.req_sel   = sel;
        bif.req_off   = off;
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            if (m_rdy) acc = cyc + 1;
            @(negedge CP); #1;
        end
        bif.req_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout sel=%0d off=%0b never accepted", sel, off);
        end
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_sel   = '0;
        bif.req_off   = 1'b0;
        repeat (3) @(negedge CP);
        #1 CDN = 1'b1;
        // OFF -> MAKE -> STABLE on input 1
        send(2'd1, 1'b0, a);
        chk("off_accept_S", 32'(bif.S), 32'h2);
        chk("pin_model_S", 32'(exp_s), 32'h2);
        chk("off_accept_ready", 32'(bif.req_ready), 0);
        idle(3);
        chk("make_not_stable", 32'(bif.sel_stable), 0);
        idle(1);
        chk("make_stable", 32'(bif.sel_stable), 1);
        chk("pin_model_stable", 32'(m_stab), 1);
        chk("stable_ready", 32'(bif.req_ready), 1);
        // switch 1 -> 2 through BREAK
        send(2'd2, 1'b0, b);
        chk("break_S0", 32'(bif.S), 0);
        idle(2);
        chk("break_S2", 32'(bif.S), 0);
        idle(1);
        chk("make_S", 32'(bif.S), 32'h4);
        chk("pin_model_make_S", 32'(exp_s), 32'h4);
        idle(3);
        chk("switch_not_stable", 32'(bif.sel_stable), 0);
        idle(1);
        chk("switch_stable", 32'(bif.sel_stable), 1);
        // same-sel no-op, then out-of-range
        send(2'd2, 1'b0, x);
        chk("same_sel_S", 32'(bif.S), 32'h4);
        chk("same_sel_stable", 32'(bif.sel_stable), 1);
        send(2'd3, 1'b0, x);
        chk("err_pulse", 32'(bif.sel_err), 1);
        chk("err_S", 32'(bif.S), 32'h4);
        idle(1);
        chk("err_one_cycle", 32'(bif.sel_err), 0);
        // release, with the next request held through BREAK
        send(2'd0, 1'b1, o);
        chk("off_S", 32'(bif.S), 0);
        chk("off_busy", 32'(bif.req_ready), 0);
        send(2'd1, 1'b0, n);
        chk("held_accept_delay", 32'(n - o), 32'(BC + 1));
        chk("off_path_S", 32'(bif.S), 32'h2);
        // asynchronous reset during MAKE
        idle(1);
        #1 CDN = 1'b0;
        #1;
        chk("async_rst_S", 32'(bif.S), 0);
        chk("async_rst_ready", 32'(bif.req_ready), 1);
        chk("async_rst_stable", 32'(bif.sel_stable), 0);
        chk("async_rst_cur", 32'(bif.cur_sel), 0);
        repeat (2) @(posedge CP);
        @(negedge CP);
        #1 CDN = 1'b1;
        send(2'd2, 1'b0, r);
        chk("post_rst_S", 32'(bif.S), 32'h4);
        idle(4);
        chk("post_rst_stable", 32'(bif.sel_stable), 1);
        for (int i = 0; i < 200; i++) begin
            idle($urandom_range(0, 5));
            send(2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, x);
        end
        idle(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nem_ohmux_sel_ctrl.md
Name: nem_ohmux_sel_ctrl

Overview:
- Upstream select-sequencer for the NEM one-hot inverting relay muxes (nem_ohmux_* family).
- Accepts a binary source-select request over a valid/ready handshake and drives the mux's one-hot select lines S[NUM_INPUTS-1:0].
- Enforces relay-safe break-before-make timing: the old relay is released, a dead time elapses, then the new relay closes. It also enforces a settle time before reporting the selection stable to downstream logic.

Parameters:
- NUM_INPUTS, 2: number of mux inputs / select lines; legal range 2..16.
- BREAK_CYCLES, 4: cycles all selects are held low between releasing one relay and closing another; minimum 1.
- MAKE_CYCLES, 8: relay pull-in settle cycles after closing before sel_stable asserts; minimum 1.
- SEL_W, max(1,$clog2(NUM_INPUTS)): width of the binary select code; derived, not overridden.

Ports:
- CP  input  1  clock, rising edge.
- CDN  input  1  asynchronous active-low reset.
- req_valid  input  1  select request present.
- req_sel  input  SEL_W  requested input index.
- req_off  input  1  with req_valid: release all relays (req_sel ignored).
- req_ready  output  1  controller can accept a request.
- S  output  NUM_INPUTS  one-hot (or all-zero) relay select, registered; S[i] drives mux Si.
- cur_sel  output  SEL_W  index of the currently/last commanded input.
- sel_stable  output  1  selected relay closed and settled; mux output valid.
- sel_err  output  1  one-cycle pulse: out-of-range req_sel rejected.

Behaviour:
- Clock and reset: one clock CP; reset CDN is asynchronous, active-low.
- Reset values (immediately while CDN=0): S=0, cur_sel=0, sel_stable=0, sel_err=0, state OFF, counter=0.
- States:
  - OFF: S=0.
  - BREAK: S=0, counting.
  - MAKE: S=onehot(cur_sel), counting.
  - STABLE: S=onehot(cur_sel), sel_stable=1.
- req_ready=1 only in OFF and STABLE. A request is accepted on the rising edge where req_valid&req_ready.
- Accept in OFF, valid sel: at that edge S<=onehot(req_sel), cur_sel<=req_sel, enter MAKE. sel_stable rises at accept edge+MAKE_CYCLES.
- Accept in STABLE, valid sel != cur_sel: at that edge S<=0, sel_stable<=0, enter BREAK.
  - S stays 0 for exactly BREAK_CYCLES cycles.
  - At accept edge+BREAK_CYCLES: S<=onehot(new), enter MAKE.
  - sel_stable rises at accept edge+BREAK_CYCLES+MAKE_CYCLES.
- Accept in STABLE, sel == cur_sel: no-op. S and sel_stable unchanged, no glitch.
- Accept in OFF with req_off: no-op. Stays OFF.
- Accept in STABLE with req_off: S<=0, sel_stable<=0, enter BREAK. After BREAK_CYCLES go to OFF, not MAKE.
- req_sel >= NUM_INPUTS, without req_off: request is consumed, sel_err pulses high the following cycle, and state/S are unchanged.
- Invariants:
  - popcount(S) <= 1 on every cycle.
  - S never changes directly from one nonzero value to another.
  - sel_stable implies S == onehot(cur_sel).
- Counter width covers max(BREAK_CYCLES,MAKE_CYCLES). It is loaded with N-1 on state entry, decrements to 0, and never wraps.
- req_valid while busy: req_ready=0. The request must be held by the producer; nothing is latched internally.
- Reset asserted mid-BREAK/MAKE: S drops to 0 asynchronously. Downstream treats the relays as released; this is safe by construction.

Decomposition:
- Shared package nem_mux_pkg:
  - state enum sel_state_e {OFF,BREAK,MAKE,STABLE};
  - function onehot(idx,N);
  - default BREAK_CYCLES/MAKE_CYCLES constants for the relay process corner.
- Optional sub-module nem_dwell_timer: loadable down-counter with a done flag, instantiated once. The FSM and output registers stay in the top.

Test Plan (NUM_INPUTS=3, BREAK_CYCLES=3, MAKE_CYCLES=4 unless noted):
- Reset: CDN low asynchronously between edges -> S=000, sel_stable=0, req_ready=1 immediately. Hold CDN low across 2 edges -> all outputs unchanged.
- From OFF, req_sel=1 accepted at edge E -> S=010 after E, req_ready=0, sel_stable=1 after E+4, req_ready=1 at E+4.
- From STABLE sel=1, req_sel=2 at edge E -> S=000 for edges E..E+2, S=100 after E+3, sel_stable=1 after E+7. Assertion: popcount(S)<=1 every cycle.
- Same-sel request (req_sel=1 while stable on 1) -> accepted in one cycle, S and sel_stable unchanged. req_sel=3 -> sel_err=1 for exactly one cycle, S unchanged.
- req_off from STABLE at E -> S=000 after E, OFF and req_ready=1 after E+3. A req_valid held during BREAK is not accepted until ready.
- Reset during MAKE (one cycle after S=010) -> S=000 asynchronously, state OFF. The next request takes the OFF path with no BREAK.
